// File: rtl/sdram_frame_seq_if.sv
// sdram_frame_seq_if
//   Bundles every non-clock/reset signal of the frame sequencer into one bus.
//   master : the sequencer itself (drives status, SDRAM requests, output stream)
//   slave  : the environment (control, ADC front end, SDRAM controller, host link)
//
//   Control : start (in), busy (out), done (out)
//   ADC     : adc_valid, adc_data (in)
//   Write   : wren, waddr, wdata (out); wstatus (in, write path empty)
//   Read    : rd, raddr (out); rdata, rdv (in); rstatus (in, monitor only)
//   Stream  : out_valid, out_data (out); out_ready (in)
interface sdram_frame_seq_if #(
  parameter int P_DATA_NBIT = 16,
  parameter int P_ADDR_NBIT = 16
);
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   adc_valid;
  logic [P_DATA_NBIT-1:0] adc_data;
  logic                   wren;
  logic [P_ADDR_NBIT-1:0] waddr;
  logic [P_DATA_NBIT-1:0] wdata;
  logic                   wstatus;
  logic                   rd;
  logic [P_ADDR_NBIT-1:0] raddr;
  logic [P_DATA_NBIT-1:0] rdata;
  logic                   rdv;
  logic                   rstatus;
  logic                   out_valid;
  logic [P_DATA_NBIT-1:0] out_data;
  logic                   out_ready;

  modport master (
    input  start, adc_valid, adc_data, wstatus, rdata, rdv, rstatus, out_ready,
    output busy, done, wren, waddr, wdata, rd, raddr, out_valid, out_data
  );

  modport slave (
    output start, adc_valid, adc_data, wstatus, rdata, rdv, rstatus, out_ready,
    input  busy, done, wren, waddr, wdata, rd, raddr, out_valid, out_data
  );
endinterface

// File: rtl/sdram_frame_seq.sv
// sdram_frame_seq
//   Captures one fixed-length frame of ADC samples into SDRAM, waits for the
//   controller's write path to drain, then reads the frame back in address
//   order through a credit-limited 8-entry FIFO onto a valid/ready stream.
//   All SDRAM addressing is owned here.
//
//   Ports:
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : sdram_frame_seq_if.master (control, ADC, SDRAM write/read, stream)
//
//   Build option:
//     SDRAM_FRAME_SEQ_TESTPAT_EN - when defined, wdata carries the write index
//     (zero-extended or truncated) instead of adc_data; adc_valid still paces.
module sdram_frame_seq #(
  parameter int P_DATA_NBIT = 16,
  parameter int P_ADDR_NBIT = 16,
  parameter int P_FRAME_LEN = 1024,
  parameter int P_BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  sdram_frame_seq_if.master   bus
);

  // Index needs one extra bit so a frame of exactly 2^P_ADDR_NBIT fits.
  localparam int                      IDX_W      = P_ADDR_NBIT + 1;
  localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(P_FRAME_LEN - 1);
  localparam logic [P_ADDR_NBIT-1:0]  BASE       = P_ADDR_NBIT'(P_BASE_ADDR);
  localparam int                      FIFO_DEPTH = 8;

  typedef enum logic [2:0] {IDLE, CAPTURE, FLUSH, READOUT, DRAIN} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       wi;
  logic [IDX_W-1:0]       ri;
  logic [1:0]             flush_cnt;
  logic [3:0]             outstanding;
  logic [3:0]             fifo_count;
  logic [2:0]             wr_ptr;
  logic [2:0]             rd_ptr;
  logic [P_DATA_NBIT-1:0] fifo_mem [FIFO_DEPTH];
  logic                   ovf_err;

  logic                   busy;
  logic                   done;
  logic                   wren;
  logic [P_ADDR_NBIT-1:0] waddr;
  logic [P_DATA_NBIT-1:0] wdata;
  logic                   rd;
  logic [P_ADDR_NBIT-1:0] raddr;
  logic                   out_valid;
  logic [P_DATA_NBIT-1:0] out_data;

  logic                   push;
  logic                   pop;
  logic                   issue;
  logic                   rdv_dec;
  logic                   head_from_push;
  logic [3:0]             outst_nxt;
  logic [3:0]             cnt_nxt;
  logic [2:0]             rd_ptr_nxt;
  logic [P_DATA_NBIT-1:0] wdata_src;

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.wren      = wren;
  assign bus.waddr     = waddr;
  assign bus.wdata     = wdata;
  assign bus.rd        = rd;
  assign bus.raddr     = raddr;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;

`ifdef SDRAM_FRAME_SEQ_TESTPAT_EN
  logic [P_DATA_NBIT+IDX_W-1:0] wi_wide;
  assign wi_wide   = {{P_DATA_NBIT{1'b0}}, wi};
  assign wdata_src = wi_wide[P_DATA_NBIT-1:0];
`else
  assign wdata_src = bus.adc_data;
`endif

  // Read returns are only accepted while a readout is in flight.
  assign push    = bus.rdv && (state == READOUT || state == DRAIN);
  assign pop     = out_valid && bus.out_ready;
  // Credit: in-flight reads plus buffered words must leave room in the FIFO,
  // so a returning read can never land on a full FIFO.
  assign issue   = (state == READOUT) &&
                   (({1'b0, outstanding} + {1'b0, fifo_count}) < 5'd8);
  assign rdv_dec = push && (outstanding != 4'd0);

  assign outst_nxt  = outstanding + {3'b000, issue} - {3'b000, rdv_dec};
  assign cnt_nxt    = fifo_count + {3'b000, push} - {3'b000, pop};
  assign rd_ptr_nxt = rd_ptr + {2'b00, pop};
  // The next head is the incoming word when the FIFO is (or becomes) empty.
  assign head_from_push = push && (fifo_count == {3'b000, pop});

  // FIFO storage: data only, contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wi          <= '0;
      ri          <= '0;
      flush_cnt   <= '0;
      outstanding <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ovf_err     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      wren        <= 1'b0;
      waddr       <= BASE;
      wdata       <= '0;
      rd          <= 1'b0;
      raddr       <= BASE;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      wren <= 1'b0;
      rd   <= 1'b0;
      done <= 1'b0;

      // Output FIFO bookkeeping, common to every state.
      outstanding <= outst_nxt;
      fifo_count  <= cnt_nxt;
      rd_ptr      <= rd_ptr_nxt;
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (push && fifo_count == 4'd8) ovf_err <= 1'b1;
      out_valid <= (cnt_nxt != 4'd0);
      if (cnt_nxt != 4'd0) begin
        out_data <= head_from_push ? bus.rdata : fifo_mem[rd_ptr_nxt];
      end

      if (issue) begin
        rd    <= 1'b1;
        raddr <= BASE + ri[P_ADDR_NBIT-1:0];
        ri    <= ri + 1'b1;
      end

      case (state)
        IDLE: begin
          wi        <= '0;
          ri        <= '0;
          flush_cnt <= '0;
          if (bus.start) begin
            busy  <= 1'b1;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (bus.adc_valid) begin
            wren  <= 1'b1;
            waddr <= BASE + wi[P_ADDR_NBIT-1:0];
            wdata <= wdata_src;
            wi    <= wi + 1'b1;
            if (wi == LAST_IDX) state <= FLUSH;
          end
        end
        FLUSH: begin
          // wstatus lags the last write by the controller's register stages;
          // ignore it until those have had time to update.
          if (flush_cnt != 2'd3) flush_cnt <= flush_cnt + 2'd1;
          else if (bus.wstatus)  state     <= READOUT;
        end
        READOUT: begin
          if (issue && ri == LAST_IDX) state <= DRAIN;
        end
        DRAIN: begin
          if (outst_nxt == 4'd0 && cnt_nxt == 4'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
